// File: rtl/legv8_pkg.sv
// Shared LEGv8 memory-stage types: FSM states, write-back error codes and the
// control bits that must survive past the EX/MEM capture edge.
package legv8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RETIRE = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    // Branch bits are resolved at capture time, so only memory/WB controls are kept.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads the execute-stage results when load_en is high,
// otherwise holds them for the duration of a memory access.
module ex_mem_reg
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [ADDR_W-1:0] add_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        rd_i,
    input  mem_ctrl_t         ctrl_i,
    output logic [ADDR_W-1:0] alu_result_o,
    output logic [ADDR_W-1:0] add_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [4:0]        rd_o,
    output mem_ctrl_t         ctrl_o
);

    logic [ADDR_W-1:0] alu_result_q, alu_result_d;
    logic [ADDR_W-1:0] add_result_q, add_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [4:0]        rd_q, rd_d;
    mem_ctrl_t         ctrl_q, ctrl_d;

    always_comb begin
        alu_result_d = alu_result_q;
        add_result_d = add_result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        if (load_en) begin
            alu_result_d = alu_result_i;
            add_result_d = add_result_i;
            store_data_d = store_data_i;
            rd_d         = rd_i;
            ctrl_d       = ctrl_i;
        end
    end

    // Cleared on reset because these registers drive dmem_addr/wdata/we directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            add_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            add_result_q <= add_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign alu_result_o = alu_result_q;
    assign add_result_o = add_result_q;
    assign store_data_o = store_data_q;
    assign rd_o         = rd_q;
    assign ctrl_o       = ctrl_q;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: owns the EX/MEM register, resolves branches, runs LDUR/STUR
// through a req/ready data-memory handshake with timeout, and retires to write-back.
module mem_stage
    import legv8_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] add_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd,
    input  logic              ctrl_branch,
    input  logic              ctrl_uncond,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_mem_to_reg,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic [ADDR_W-1:0] branch_target_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_rd,
    output logic [ADDR_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [1:0]        wb_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              from_acc_q, from_acc_d;
    logic              pc_src_q, pc_src_d;
    logic              dmem_req_q, dmem_req_d;
    logic              stall_q, stall_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [ADDR_W-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [DATA_W-1:0] wb_read_data_q, wb_read_data_d;
    logic [1:0]        wb_err_q, wb_err_d;

    logic              cap_en;
    mem_ctrl_t         ctrl_in;
    logic [ADDR_W-1:0] cap_alu, cap_add;
    logic [DATA_W-1:0] cap_wdata;
    logic [4:0]        cap_rd;
    mem_ctrl_t         cap_ctrl;
    logic              in_is_mem, in_aligned, cap_is_load;

    assign ctrl_in     = '{mem_read: ctrl_mem_read, mem_write: ctrl_mem_write,
                           reg_write: ctrl_reg_write, mem_to_reg: ctrl_mem_to_reg};
    assign in_is_mem   = ctrl_mem_read | ctrl_mem_write;
    assign in_aligned  = (alu_result[2:0] == 3'b000);
    // A store wins when both read and write are set.
    assign cap_is_load = cap_ctrl.mem_read & ~cap_ctrl.mem_write;

    ex_mem_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ex_mem (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (cap_en),
        .alu_result_i (alu_result),
        .add_result_i (add_result),
        .store_data_i (store_data),
        .rd_i         (rd),
        .ctrl_i       (ctrl_in),
        .alu_result_o (cap_alu),
        .add_result_o (cap_add),
        .store_data_o (cap_wdata),
        .rd_o         (cap_rd),
        .ctrl_o       (cap_ctrl)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        from_acc_d      = from_acc_q;
        pc_src_d        = 1'b0;
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_rd_d         = wb_rd_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_read_data_d  = wb_read_data_q;
        wb_err_d        = wb_err_q;
        cap_en          = 1'b0;

        case (state_q)
            ST_IDLE, ST_RETIRE: begin
                if (state_q == ST_RETIRE) begin
                    state_d    = ST_IDLE;
                    from_acc_d = 1'b0;
                end
                // A retire that did not touch memory can overlap the next capture.
                if (in_valid && !from_acc_q) begin
                    cap_en   = 1'b1;
                    pc_src_d = ctrl_uncond | (ctrl_branch & zero);
                    if (in_is_mem && in_aligned) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = '0;
                        from_acc_d = 1'b1;
                    end else begin
                        state_d         = ST_RETIRE;
                        from_acc_d      = 1'b0;
                        wb_valid_d      = 1'b1;
                        wb_rd_d         = rd;
                        wb_alu_result_d = alu_result;
                        wb_mem_to_reg_d = ctrl_mem_to_reg;
                        wb_read_data_d  = '0;
                        wb_err_d        = in_is_mem ? ERR_MISALIGN : ERR_NONE;
                        wb_reg_write_d  = in_is_mem ? 1'b0 : ctrl_reg_write;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ready || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d         = ST_RETIRE;
                    wb_valid_d      = 1'b1;
                    wb_rd_d         = cap_rd;
                    wb_alu_result_d = cap_alu;
                    wb_mem_to_reg_d = cap_ctrl.mem_to_reg;
                    if (dmem_ready) begin
                        wb_err_d       = ERR_NONE;
                        wb_reg_write_d = cap_ctrl.reg_write;
                        wb_read_data_d = cap_is_load ? dmem_rdata : '0;
                    end else begin
                        wb_err_d       = ERR_TIMEOUT;
                        wb_reg_write_d = 1'b0;
                        wb_read_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                from_acc_d = 1'b0;
            end
        endcase

        dmem_req_d = (state_d == ST_ACCESS);
        stall_d    = (state_d == ST_ACCESS) || (state_d == ST_RETIRE && from_acc_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            from_acc_q      <= 1'b0;
            pc_src_q        <= 1'b0;
            dmem_req_q      <= 1'b0;
            stall_q         <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_result_q <= '0;
            wb_read_data_q  <= '0;
            wb_err_q        <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            from_acc_q      <= from_acc_d;
            pc_src_q        <= pc_src_d;
            dmem_req_q      <= dmem_req_d;
            stall_q         <= stall_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_q         <= wb_rd_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_err_q        <= wb_err_d;
        end
    end

    assign stall_o         = stall_q;
    assign pc_src_o        = pc_src_q;
    assign branch_target_o = cap_add;
    assign dmem_req        = dmem_req_q;
    assign dmem_we         = cap_ctrl.mem_write;
    assign dmem_addr       = cap_alu;
    assign dmem_wdata      = cap_wdata;
    assign wb_valid        = wb_valid_q;
    assign wb_reg_write    = wb_reg_write_q;
    assign wb_mem_to_reg   = wb_mem_to_reg_q;
    assign wb_rd           = wb_rd_q;
    assign wb_alu_result   = wb_alu_result_q;
    assign wb_read_data    = wb_read_data_q;
    assign wb_err          = wb_err_q;

endmodule
